final_sum_reduce: RTL
=====================

Name: final_sum_reduce

Overview:
- Downstream consumer of the function-evaluation accumulator.
- When the top level services a READ, this block adds the two partial sums (sum_one, sum_two) into one IEEE-754 single-precision result.
- It is a multi-cycle, fixed-latency floating-point adder with a start/done handshake and a working flag. That flag feeds the top-level pipeline-empty detection.

Parameters:
- FLT_DATA_WIDTH, 32, float word width (fixed; other values unsupported)
- MANT_EXT, 3, extra low-order alignment bits appended below the 24-bit significand
- STATE_WIDTH, 3, state register width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- clk_en  in  1  global enable; when low, all registers hold
- start  in  1  request; sampled only in IDLE with clk_en=1
- sum_a  in  32  partial sum one (float)
- sum_b  in  32  partial sum two (float)
- result  out  32  sum_a+sum_b (float); holds until next completion
- done  out  1  one-cycle pulse, result valid
- working  out  1  high while an operation is in flight

Behaviour:
- Reset (async, rst=1): state=IDLE, result=0x00000000, done=0, working=0, internal operand/mantissa registers cleared. Reset mid-operation aborts the operation; no done is issued.
- clk_en=0: state, internal registers, result, done and working all hold their values.
- States: IDLE -> ALIGN -> ADD -> NORM -> OUT -> IDLE.
- IDLE: done=0. If start&clk_en:
  - capture sum_a and sum_b;
  - unpack sign, exponent and 24-bit significand (hidden bit=1 if exponent!=0);
  - go to ALIGN; working=1.
- ALIGN:
  - Order operands by magnitude ({exp,frac} compare). The larger one becomes L.
  - Extend both significands to 27 bits (MANT_EXT zero LSBs).
  - Shift the smaller right by min(expL-expS, 27); shifted-out bits are discarded (no sticky).
- ADD: 28-bit result. Equal signs: sum. Differing signs: L-S. Result sign = sign of L.
- NORM: find the leading one.
  - Carry (bit27): shift right 1, exponent+1.
  - Otherwise shift left by the leading-zero count; exponent minus count.
  - Truncate to 24 bits (round toward zero on the extended value).
- OUT: pack result, done=1 for this cycle, working=0, go to IDLE.
- Latency: start accepted at edge k; result/done visible after edge k+4. Max throughput is one op per 5 cycles. start while not IDLE is ignored (not queued).
- Special cases, resolved in ALIGN and forced through to OUT:
  - Exponent=0 inputs (zero/denormal) are treated as signed zero.
  - Either input NaN: 0x7FC00000.
  - +inf + -inf: 0x7FC00000.
  - Single inf: that inf.
- Zero significand after ADD (exact cancellation, or both zero): +0 (0x00000000), except -0 + -0 = 0x80000000.
- Exponent overflow (>=255 after normalise): signed infinity.
- Exponent underflow (<=0): signed zero (flush).
- Operands are only read in IDLE; later input changes do not affect the in-flight op.

Decomposition:
- Shared package (fe_defs) holds:
  - FLT_DATA_WIDTH, CORDIC_DATA_WIDTH;
  - exponent bias 127; QNAN constant 32'h7FC00000;
  - n opcodes CLEAR/GO/READ;
  - this block's state encodings IDLE/ALIGN/ADD/NORM/OUT.
- One natural sub-module: fp_lzc28, a combinational 28-bit leading-zero counter (5-bit output, 28 when input is zero), instantiated in NORM.

Test Plan:
- Basic add: sum_a=0x3F800000 (1.0), sum_b=0x40000000 (2.0), start pulse -> done exactly 4 cycles after accept, result=0x40400000; working high for 4 cycles.
- Cancellation and truncation:
  - sum_a=0x3FC00000, sum_b=0xBFC00000 -> result=0x00000000.
  - 0x3F800000 + 0x30800000 -> 0x3F800000 (small term discarded).
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x7FC00001 + 1.0 -> 0x7FC00000.
  - 0x00000001 + 0x3F800000 -> 0x3F800000.
- Handshake:
  - start held high through an op -> exactly one done per 5 cycles.
  - A second start pulse during ALIGN is ignored; result reflects the first operands, even though sum_a/sum_b change after acceptance.
- clk_en stall: drop clk_en for 3 cycles during ADD -> done arrives 3 cycles later, result unchanged (1.0+2.0=0x40400000). done stays high for the whole stall if the stall hits OUT.
- Reset mid-op: assert rst asynchronously during NORM -> result=0, done=0, working=0 immediately with no clock. The next op after release completes normally.

Source files
------------

// File: rtl/final_sum_reduce_pkg.sv
// Shared definitions for the function-evaluation block: widths, float
// constants, top-level opcodes and the final-sum adder state encoding.
package fe_defs;

  localparam int FLT_DATA_WIDTH    = 32;
  localparam int CORDIC_DATA_WIDTH = 32;
  localparam int EXP_BIAS          = 127;
  localparam int MANT_EXT          = 3;
  localparam int STATE_WIDTH       = 3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_GO    = 2'd1,
    OP_READ  = 2'd2
  } opcode_t;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    OUT   = 3'd4
  } fsr_state_t;

  // All-ones exponent with a non-zero fraction.
  function automatic logic is_nan(input logic [31:0] f);
    return (&f[30:23]) && (|f[22:0]);
  endfunction

  // All-ones exponent with a zero fraction.
  function automatic logic is_inf(input logic [31:0] f);
    return (&f[30:23]) && !(|f[22:0]);
  endfunction

endpackage

// File: rtl/fp_lzc28.sv
// Combinational leading-zero counter for the 28-bit adder result.
// Returns 28 when the input is all zeros.
module fp_lzc28 (
  input  logic [27:0] value,
  output logic [4:0]  count
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/final_sum_reduce.sv
// Multi-cycle single-precision adder that folds the two accumulator
// partial sums into one result. Fixed 4-cycle latency, truncating,
// denormals flushed to zero, no sticky bit.
module final_sum_reduce #(
  parameter int FLT_DATA_WIDTH = 32,
  parameter int MANT_EXT       = 3,
  parameter int STATE_WIDTH    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      start,
  input  logic [FLT_DATA_WIDTH-1:0] sum_a,
  input  logic [FLT_DATA_WIDTH-1:0] sum_b,
  output logic [FLT_DATA_WIDTH-1:0] result,
  output logic                      done,
  output logic                      working
);
  import fe_defs::*;

  localparam int MW = 24 + MANT_EXT;  // extended significand
  localparam int SW = MW + 1;         // adder result incl. carry

  logic [STATE_WIDTH-1:0] state;
  logic [31:0]            op_a, op_b;
  logic                   sign_l, sign_s;
  logic [7:0]             exp_l;
  logic [MW-1:0]          man_l, man_s;
  logic [SW-1:0]          sum;
  logic                   special;
  logic [31:0]            packed_q;

  // ---- ALIGN-stage combinational view of the captured operands ----
  logic        zero_a, zero_b, a_big, l_zero, s_zero, spec_hit;
  logic [30:0] key_a, key_b;
  logic [31:0] l_word, s_word, spec_word;
  logic [7:0]  exp_diff, shamt;
  logic [MW-1:0] man_lx, man_sx;

  // Order by magnitude (zeros compare as 0), extend, and resolve specials.
  always_comb begin
    zero_a    = (op_a[30:23] == 8'd0);
    zero_b    = (op_b[30:23] == 8'd0);
    key_a     = zero_a ? 31'd0 : op_a[30:0];
    key_b     = zero_b ? 31'd0 : op_b[30:0];
    a_big     = (key_a >= key_b);
    l_word    = a_big ? op_a : op_b;
    s_word    = a_big ? op_b : op_a;
    l_zero    = a_big ? zero_a : zero_b;
    s_zero    = a_big ? zero_b : zero_a;
    man_lx    = l_zero ? '0 : {1'b1, l_word[22:0], {MANT_EXT{1'b0}}};
    man_sx    = s_zero ? '0 : {1'b1, s_word[22:0], {MANT_EXT{1'b0}}};
    exp_diff  = l_word[30:23] - s_word[30:23];
    shamt     = (exp_diff > 8'(MW)) ? 8'(MW) : exp_diff;
    spec_hit  = 1'b1;
    spec_word = QNAN;
    if (is_nan(op_a) || is_nan(op_b))       spec_word = QNAN;
    else if (is_inf(op_a) && is_inf(op_b))  spec_word = (op_a[31] != op_b[31]) ? QNAN : op_a;
    else if (is_inf(op_a))                  spec_word = op_a;
    else if (is_inf(op_b))                  spec_word = op_b;
    else begin
      spec_hit  = 1'b0;
      spec_word = 32'd0;
    end
  end

  // ---- NORM-stage combinational normalise and pack ----
  logic [4:0]        lz, lz_m1;
  logic [SW-1:0]     norm_sh;
  logic signed [9:0] exp_n;
  logic [22:0]       frac_n;
  logic [31:0]       norm_word;
  logic [3:0]        unused_norm_bits;

  fp_lzc28 u_lzc (.value(sum), .count(lz));

  // Leading one lands on bit MW-1; a carry shifts right instead.
  always_comb begin
    lz_m1   = lz - 5'd1;
    norm_sh = sum << lz_m1;
    if (sum[SW-1]) begin
      exp_n  = $signed({2'b00, exp_l}) + 10'sd1;
      frac_n = sum[SW-2 -: 23];
    end else begin
      exp_n  = $signed({2'b00, exp_l}) - $signed({5'b00000, lz_m1});
      frac_n = norm_sh[MW-2 -: 23];
    end
    if (sum == '0)              norm_word = {sign_l & sign_s, 31'd0};
    else if (exp_n >= 10'sd255) norm_word = {sign_l, 8'hFF, 23'd0};
    else if (exp_n <= 10'sd0)   norm_word = {sign_l, 31'd0};
    else                        norm_word = {sign_l, exp_n[7:0], frac_n};
  end

  assign unused_norm_bits = {norm_sh[SW-1], norm_sh[2:0]};

  // Sequencer: IDLE -> ALIGN -> ADD -> NORM -> OUT, all stalled by clk_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      sign_l   <= 1'b0;
      sign_s   <= 1'b0;
      exp_l    <= '0;
      man_l    <= '0;
      man_s    <= '0;
      sum      <= '0;
      special  <= 1'b0;
      packed_q <= '0;
      result   <= '0;
      done     <= 1'b0;
      working  <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_a    <= sum_a;
          op_b    <= sum_b;
          working <= 1'b1;
          state   <= ALIGN;
        end
        ALIGN: begin
          sign_l   <= l_word[31];
          sign_s   <= s_word[31];
          exp_l    <= l_word[30:23];
          man_l    <= man_lx;
          man_s    <= man_sx >> shamt;
          special  <= spec_hit;
          packed_q <= spec_word;
          state    <= ADD;
        end
        ADD: begin
          if (!special)
            sum <= (sign_l == sign_s) ? ({1'b0, man_l} + {1'b0, man_s})
                                      : ({1'b0, man_l} - {1'b0, man_s});
          state <= NORM;
        end
        NORM: begin
          if (!special) packed_q <= norm_word;
          state <= OUT;
        end
        OUT: begin
          result  <= packed_q;
          done    <= 1'b1;
          working <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
